// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: R = A - B - B_in, W bits per cycle, with NZCV flags.
// Optional macro SUB_SAT_EN saturates R on signed overflow.
module serial_subtractor #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         B_in,
  output logic [N-1:0] R,
  output logic         N_flag,
  output logic         Z_flag,
  output logic         C_flag,
  output logic         V_flag,
  output logic         busy,
  output logic         done
);

  localparam int unsigned D    = N / W;
  localparam int unsigned CntW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, a_d, b_q, b_d, acc_q, acc_d, r_q, r_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic [W-1:0]      a_dig, b_dig;
  logic [W:0]        dig_diff;
  logic [N-1:0]      res_full, res_out;
  logic              ovf;

  // Datapath for the digit selected by the counter; res_full is only complete on the last digit.
  always_comb begin
    a_dig    = a_q[cnt_q*W +: W];
    b_dig    = b_q[cnt_q*W +: W];
    dig_diff = {1'b0, a_dig} - {1'b0, b_dig} - {{W{1'b0}}, borrow_q};
    res_full = acc_q;
    res_full[cnt_q*W +: W] = dig_diff[W-1:0];
    ovf      = (a_q[N-1] != b_q[N-1]) && (res_full[N-1] != a_q[N-1]);
    res_out  = res_full;
`ifdef SUB_SAT_EN
    if (ovf) begin
      res_out = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = B_in;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        acc_d    = res_full;
        borrow_d = dig_diff[W];
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(D - 1)) begin
          r_d     = res_out;
          n_d     = res_out[N-1];
          z_d     = ~|res_out;
          c_d     = ~dig_diff[W];
          v_d     = ovf;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  assign R      = r_q;
  assign N_flag = n_q;
  assign Z_flag = z_q;
  assign C_flag = c_q;
  assign V_flag = v_q;
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized operations
// against a whole-word arithmetic reference model.
module tb_serial_subtractor;

  logic        clk, rst, start, B_in;
  logic [31:0] A, B, R;
  logic        N_flag, Z_flag, C_flag, V_flag, busy, done;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.N(32), .W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .B_in(B_in),
    .R(R), .N_flag(N_flag), .Z_flag(Z_flag), .C_flag(C_flag), .V_flag(V_flag),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: full-width subtraction, returns {R, N, Z, C, V}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic bin);
    logic [32:0] full;
    logic [31:0] r;
    logic        c, v;
    full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    r    = full[31:0];
    c    = ~full[32];
    v    = (a[31] != b[31]) && (r[31] != a[31]);
`ifdef SUB_SAT_EN
    if (v) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic [35:0] observed();
    return {R, N_flag, Z_flag, C_flag, V_flag};
  endfunction

  // Starts an op from IDLE/DONE (called #1 after an edge); returns #1 after the done edge.
  task automatic launch_and_wait(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                 output int nbusy, output bit seen_done);
    A = a; B = b; B_in = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) begin
        nbusy++;
        A = $urandom; B = $urandom; B_in = 1'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({observed(), busy, done} !== 38'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h required 0", {observed(), busy, done});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'd5, 32'd0, 32'h8000_0000, 32'd7, 32'd0, 32'h7FFF_FFFF};
    logic [31:0] tb [6] = '{32'd3, 32'd1, 32'd1, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef SUB_SAT_EN
    logic [31:0] er [6] = '{32'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                            32'h7FFF_FFFF};
    logic [3:0]  ef [6] = '{4'b0010, 4'b1000, 4'b1011, 4'b1000, 4'b0110, 4'b0001};
`else
    logic [31:0] er [6] = '{32'd2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                            32'h8000_0000};
    logic [3:0]  ef [6] = '{4'b0010, 4'b1000, 4'b0011, 4'b1000, 4'b0110, 4'b1001};
`endif
    int nbusy;
    bit seen;
    for (int i = 0; i < 6; i++) begin
      launch_and_wait(ta[i], tb[i], tc[i], nbusy, seen);
      vectors++;
      if (!seen || nbusy != 8) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: done=%0b busy_cycles=%0d required done=1 busy=8",
                 i, seen, nbusy);
      end
      vectors++;
      if (observed() !== {er[i], ef[i]}) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got R=%h NZCV=%b required R=%h NZCV=%b",
                 i, R, {N_flag, Z_flag, C_flag, V_flag}, er[i], ef[i]);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_pulse[%0d]: got done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int nbusy, dones;
    bit seen;
    launch_and_wait(32'd0, 32'd1, 1'b0, nbusy, seen);  // leave a nonzero R behind
    @(posedge clk); #1;
    A = 32'd5; B = 32'd3; B_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({observed(), busy, done} !== 38'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got %h required 0", {observed(), busy, done});
    end
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d done pulses required 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int nbusy;
    bit seen;
    launch_and_wait(32'd7, 32'd7, 1'b0, nbusy, seen);
    vectors++;
    if (!seen || observed() !== {32'd0, 4'b0110}) begin
      miscompares++;
      $display("FAIL b2b_first: done=%0b got %h required %h", seen, observed(),
               {32'd0, 4'b0110});
    end
    // Still in DONE: start held here must be accepted with no idle cycle.
    launch_and_wait(32'd7, 32'd6, 1'b1, nbusy, seen);
    vectors++;
    if (!seen || nbusy + 1 != 9) begin
      miscompares++;
      $display("FAIL b2b_spacing: done=%0b got %0d cycles required 9", seen, nbusy + 1);
    end
    vectors++;
    if (observed() !== {32'd0, 4'b0110}) begin
      miscompares++;
      $display("FAIL b2b_second: got %h required %h", observed(), {32'd0, 4'b0110});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    logic [35:0] exp, got;
    int dones;
    exp = model(32'h1234_5678, 32'h0000_1111, 1'b0);
    got = '0;
    A = 32'h1234_5678; B = 32'h0000_1111; B_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 32'hFFFF_FFFF; B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        dones++;
        got = observed();
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL busy_start_pulses: got %0d done pulses required 1", dones);
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL busy_start_result: got %h required %h", got, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        bin;
    logic [35:0] exp;
    int nbusy;
    bit seen;
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      bin = 1'($urandom);
      exp = model(a, b, bin);
      launch_and_wait(a, b, bin, nbusy, seen);
      vectors++;
      if (!seen || nbusy != 8 || observed() !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h bin=%b: done=%0b busy=%0d got %h required %h",
                 i, a, b, bin, seen, nbusy, observed(), exp);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_back_to_back();
    test_start_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
